// File: rtl/fsm_event_monitor.sv
// Event monitor for the sequence-detector output: counts rising edges of y_in and
// queues the cycle intervals between consecutive edges in a first-word-fall-through FIFO.
module fsm_event_monitor #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned EVT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     y_in,
    input  logic                     clear,
    input  logic                     rd_en,
    output logic [CNT_W-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [EVT_W-1:0]         event_count,
    output logic                     overflow,
    output logic                     timeout
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    localparam logic [CNT_W-1:0] GAP_MAX  = '1;
    localparam logic [CNT_W-1:0] GAP_ONE  = CNT_W'(1);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [LW-1:0]    LVL_ONE  = LW'(1);
    localparam logic [LW-1:0]    LVL_FULL = LW'(DEPTH);
    localparam logic [EVT_W-1:0] EVT_ONE  = EVT_W'(1);

    typedef enum logic [1:0] {StIdle, StRun, StSat} state_e;

    state_e             state_q, state_d;
    logic               y_q;
    logic [CNT_W-1:0]   gap_q, gap_d, gap_inc;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      level_q, level_d;
    logic [EVT_W-1:0]   evt_q, evt_d;
    logic               ovf_q, ovf_d, tmo_q, tmo_d;
    logic [CNT_W-1:0]   mem [DEPTH];

    logic               rise, push, do_push, do_pop;
    logic [CNT_W-1:0]   push_val;

    assign rise    = y_in & ~y_q;
    assign gap_inc = gap_q + GAP_ONE;

    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        tmo_d    = tmo_q;
        push     = 1'b0;
        push_val = gap_q;
        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    gap_d   = GAP_ONE;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (rise) begin
                    push  = 1'b1;
                    gap_d = GAP_ONE;
                end else begin
                    gap_d = gap_inc;
                    if (gap_inc == GAP_MAX) begin
                        state_d = StSat;
                        tmo_d   = 1'b1;
                    end
                end
            end
            StSat: begin
                gap_d = GAP_MAX;
                if (rise) begin
                    push     = 1'b1;
                    push_val = GAP_MAX;
                    gap_d    = GAP_ONE;
                    state_d  = StRun;
                end
            end
            default: begin
                state_d = StIdle;
                gap_d   = '0;
            end
        endcase
    end

    // A pop frees the slot in the same cycle, so a push while full still lands.
    always_comb begin
        do_pop   = rd_en & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        level_d  = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + LVL_ONE;
        end else if (do_pop && !do_push) begin
            level_d = level_q - LVL_ONE;
        end
        ovf_d = ovf_q | (push & ~do_push);
        evt_d = rise ? evt_q + EVT_ONE : evt_q;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            y_q      <= 1'b0;
            state_q  <= StIdle;
            gap_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            evt_q    <= '0;
            ovf_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            y_q      <= y_in;
            state_q  <= state_d;
            gap_q    <= gap_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            evt_q    <= evt_d;
            ovf_q    <= ovf_d;
            tmo_q    <= tmo_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !clear && do_push) begin
            mem[wr_ptr_q] <= push_val;
        end
    end

    assign empty       = (level_q == '0);
    assign full        = (level_q == LVL_FULL);
    assign fifo_level  = level_q;
    assign rd_data     = empty ? '0 : mem[rd_ptr_q];
    assign event_count = evt_q;
    assign overflow    = ovf_q;
    assign timeout     = tmo_q;

endmodule
